// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave
// Description : SPI slave clocked entirely by the system clock. The serial
//               clock, MOSI and chip select are brought in through 2-flop
//               synchronizers, and frame timing is decoded from edges of the
//               synchronized serial clock. Works in all four CPOL/CPHA modes.
//               Frames are MSB first and exactly one word long.
// Ports       : clk, rst         - system clock, asynchronous active-high reset
//               spi_clk/mosi/cs_n - serial interface inputs from the master
//               spi_miso          - serial data to the master
//               data_tx, tx_load  - transmit word and its capture strobe
//               tx_pending        - a loaded word is waiting for a frame
//               data_rx, rx_valid - last received word and its update pulse
//               busy              - a frame is in progress
//               frame_err         - pulse: frame aborted before bit 0
//               tx_underrun       - pulse: frame started with no word loaded
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave #(
    parameter int   SPI_PACKET_SIZE = 8,
    parameter logic SPI_MISO_IDLE   = 1'b1,
    parameter logic SPI_CPOL        = 1'b0,
    parameter logic SPI_CPHA        = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       spi_clk,
    input  logic                       spi_mosi,
    input  logic                       spi_cs_n,
    output logic                       spi_miso,
    input  logic [SPI_PACKET_SIZE-1:0] data_tx,
    input  logic                       tx_load,
    output logic                       tx_pending,
    output logic [SPI_PACKET_SIZE-1:0] data_rx,
    output logic                       rx_valid,
    output logic                       busy,
    output logic                       frame_err,
    output logic                       tx_underrun
);

    localparam int                     c_CW  = $clog2(SPI_PACKET_SIZE);
    localparam logic [c_CW-1:0]        c_TOP = c_CW'(SPI_PACKET_SIZE - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic                       r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic                       r_mosi_meta, r_mosi_sync;
    logic                       r_cs_meta, r_cs_sync, r_cs_prev;
    logic [1:0]                 r_warm;

    logic [SPI_PACKET_SIZE-1:0] r_tx_hold;
    logic [SPI_PACKET_SIZE-1:0] r_tx_shift;
    logic [SPI_PACKET_SIZE-1:0] r_rx_shift;
    logic [c_CW-1:0]            r_bit_cnt;
    logic                       r_done;
    logic                       r_first_shift;
    logic                       r_commit;

    logic w_rise, w_fall, w_lead, w_trail, w_sample, w_shift;
    logic w_cs_fall, w_cs_rise, w_start, w_stop;

    // ------------------------------------------------------------------------
    // Input synchronizers. Chip select resets to the deselected level. The
    // warm-up counter blocks chip-select fall detection until both the
    // synchronized and the previous value hold real samples, so a chip
    // select held low through reset release is not taken as a new frame.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_cs_prev   <= 1'b1;
            r_warm      <= 2'd0;
        end else begin
            r_sclk_meta <= spi_clk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_mosi_meta <= spi_mosi;
            r_mosi_sync <= r_mosi_meta;
            r_cs_meta   <= spi_cs_n;
            r_cs_sync   <= r_cs_meta;
            r_cs_prev   <= r_cs_sync;
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end
        end
    end

    assign w_rise    = r_sclk_sync & ~r_sclk_prev;
    assign w_fall    = ~r_sclk_sync & r_sclk_prev;
    assign w_lead    = SPI_CPOL ? w_fall : w_rise;
    assign w_trail   = SPI_CPOL ? w_rise : w_fall;
    assign w_sample  = SPI_CPHA ? w_trail : w_lead;
    assign w_shift   = SPI_CPHA ? w_lead : w_trail;
    assign w_cs_fall = (r_warm == 2'd3) & r_cs_prev & ~r_cs_sync;
    assign w_cs_rise = r_cs_sync & ~r_cs_prev;
    assign w_start   = (r_state == S_IDLE) & w_cs_fall;
    assign w_stop    = (r_state == S_ACTIVE) & w_cs_rise;

    // ------------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        spi_miso    = SPI_MISO_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                busy     = 1'b1;
                spi_miso = r_tx_shift[r_bit_cnt];
                if (w_cs_rise) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: holding register, shift registers, bit counter, pulses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_hold     <= '0;
            r_tx_shift    <= '0;
            r_rx_shift    <= '0;
            r_bit_cnt     <= '0;
            r_done        <= 1'b0;
            r_first_shift <= 1'b0;
            r_commit      <= 1'b0;
            tx_pending    <= 1'b0;
            data_rx       <= '0;
            rx_valid      <= 1'b0;
            frame_err     <= 1'b0;
            tx_underrun   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
            r_commit    <= 1'b0;

            // Completed word is published one cycle after its last sample.
            if (r_commit) begin
                data_rx  <= r_rx_shift;
                rx_valid <= 1'b1;
            end

            if (w_start) begin
                r_tx_shift    <= tx_pending ? r_tx_hold : {SPI_PACKET_SIZE{SPI_MISO_IDLE}};
                tx_pending    <= 1'b0;
                tx_underrun   <= ~tx_pending;
                r_bit_cnt     <= c_TOP;
                r_done        <= 1'b0;
                r_first_shift <= 1'b1;
                r_rx_shift    <= '0;
            end else if ((r_state == S_ACTIVE) && !w_stop && !r_done) begin
                if (w_sample) begin
                    r_rx_shift[r_bit_cnt] <= r_mosi_sync;
                    if (r_bit_cnt == '0) begin
                        r_done   <= 1'b1;
                        r_commit <= 1'b1;
                    end
                end
                // In CPHA=1 the first leading edge only announces bit N-1,
                // which is already on the line, so it does not advance.
                if (w_shift) begin
                    if (SPI_CPHA && r_first_shift) begin
                        r_first_shift <= 1'b0;
                    end else if (r_bit_cnt != '0) begin
                        r_bit_cnt <= r_bit_cnt - c_CW'(1);
                    end
                end
            end

            if (w_stop && !r_done) begin
                frame_err <= 1'b1;
            end

            // After the frame-start copy so a same-cycle load waits for the
            // next frame instead of being dropped.
            if (tx_load) begin
                r_tx_hold  <= data_tx;
                tx_pending <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
